register_bank_mp: RTL and testbench
===================================

Name: register_bank_mp

Overview:
- Parametrised successor to the CPU's 8-entry register bank.
- Adds a second dynamic read port and optional write-to-read bypass.
- Adds hardware PC auto-increment, SP push/pop with overflow/underflow detection, and write protection of the constant register.
- Sits between the control unit and the ALU datapath; the fixed accumulator bus still feeds ALU operand A.

Parameters:
- DATA_WIDTH, 8: register width in bits.
- ADDR_WIDTH, 3: address width; depth is 2**ADDR_WIDTH.
- PC_ADDR, 0: program counter index.
- SP_ADDR, 1: stack pointer index.
- CONST_ADDR, 6: read-only constant index.
- ACC_ADDR, 7: accumulator index, driven on bus_acc.
- BYPASS, 1: 1 means a same-cycle write is forwarded to the read buses; 0 means reads see only stored values.
- INIT_VEC, {F0,FF,00,04,03,00,FF,00} (entry 0 at LSB): concatenated reset values, DATA_WIDTH*2**ADDR_WIDTH bits.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- w_en, in, 1: general write enable.
- w_addr, in, ADDR_WIDTH: write address.
- w_data, in, DATA_WIDTH: write data.
- r_addr_a, in, ADDR_WIDTH: read address, port A.
- r_addr_b, in, ADDR_WIDTH: read address, port B.
- pc_inc, in, 1: increment PC this cycle.
- sp_op, in, 2: stack op; 00 none, 01 push (SP-1), 10 pop (SP+1), 11 no-op.
- flag_clr, in, 1: clear sticky flags.
- bus_acc, out, DATA_WIDTH: value of ACC_ADDR.
- bus_a, out, DATA_WIDTH: read data, port A.
- bus_b, out, DATA_WIDTH: read data, port B.
- sp_ovf, out, 1: sticky; push attempted at SP==0.
- sp_unf, out, 1: sticky; pop attempted at SP==all-ones.
- wr_err, out, 1: sticky; write attempted to CONST_ADDR.

Behaviour:
- Reset (async, rst=1):
  - entry i <= INIT_VEC[i*DATA_WIDTH +: DATA_WIDTH].
  - All flags <= 0.
  - With defaults, outputs read bus_acc=F0, bus_a/bus_b = the addressed init values.
  - Asserting rst mid-operation overrides every pending write, pc_inc and sp_op that cycle.
- Reads: combinational, zero latency, on all three buses.
- Bypass (BYPASS=1): if w_en and w_addr equals a bus's address and w_addr != CONST_ADDR, that bus shows w_data in the same cycle. Bypass covers the general write port only; PC/SP updates appear the cycle after the edge.
- General write: on the rising edge, if w_en, entry[w_addr] <= w_data.
  - If w_addr==CONST_ADDR: no write, wr_err <= 1.
- PC: if pc_inc and not (w_en and w_addr==PC_ADDR), PC <= PC+1 modulo 2**DATA_WIDTH (FF wraps to 00, no flag). A general write to PC has priority over pc_inc.
- SP push (sp_op=01):
  - SP!=0: SP <= SP-1.
  - SP==0: SP unchanged, sp_ovf <= 1.
- SP pop (sp_op=10):
  - SP!=all-ones: SP <= SP+1.
  - SP==all-ones: SP unchanged, sp_unf <= 1.
- SP priority: a general write to SP has priority over sp_op. The op is dropped and no flag is raised, even at a boundary.
- Concurrency: pc_inc, sp_op and a general write to a third address all complete in the same cycle.
- Flags:
  - Sticky until flag_clr or rst.
  - If flag_clr coincides with a new flag event, set wins (the flag reads 1 next cycle).
- Parameter constraint: PC_ADDR, SP_ADDR, CONST_ADDR and ACC_ADDR must be distinct and < 2**ADDR_WIDTH. An initial-block check stops elaboration otherwise.
- The constant register is writable only through INIT_VEC at reset.

Decomposition:
- Shared include (regbank_defs.vh):
  - sp_op encodings SP_NONE, SP_PUSH, SP_POP.
  - Default symbolic addresses PC/SP/DPTR/AREG/TVP/TEMP/CTE_NEGONE/ACC.
  - Default INIT_VEC constant, so the control unit and decoder use the same values.
- Sub-module sp_unit (DATA_WIDTH param):
  - Inputs: current SP, sp_op, write override.
  - Outputs: next SP, ovf/unf event pulses.
  - Keeps the boundary logic separately testable.
- Storage array and bypass muxes stay in the top module.

Test Plan:
- Reset values: assert rst mid-cycle with w_en=1, w_addr=3, w_data=AA → after release, r_addr_a=3 gives 03, r_addr_b=1 gives FF, bus_acc=F0, all flags 0.
- Bypass and write protection: w_en, w_addr=7, w_data=5A with BYPASS=1 → bus_acc=5A in the same cycle and stays 5A after the edge. w_addr=6, w_data=00 → bus_b(6) stays FF, wr_err=1 next cycle.
- PC wrap and priority: PC=FE, pc_inc for 2 cycles → FF then 00. pc_inc together with a write of 40 to PC → PC=40.
- SP boundaries: from reset, pop → SP stays FF, sp_unf=1. Write SP=01, push twice → 00, then 00 with sp_ovf=1. flag_clr → both flags 0.
- Set-over-clear: flag_clr together with a push at SP=00 → sp_ovf remains 1.
- Concurrency: pc_inc, push and a write of 77 to TEMP(5) in one cycle → PC+1, SP-1, TEMP=77, all visible next cycle on the read ports.

Source files
------------

// File: rtl/register_bank_mp_pkg.sv
// Shared definitions for the multi-port register bank: stack-op encodings,
// symbolic register addresses and the default reset image.
package register_bank_mp_pkg;

    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_PUSH = 2'b01,
        SP_POP  = 2'b10,
        SP_NOP  = 2'b11
    } sp_op_e;

    localparam int ADDR_PC         = 0;
    localparam int ADDR_SP         = 1;
    localparam int ADDR_DPTR       = 2;
    localparam int ADDR_AREG       = 3;
    localparam int ADDR_TVP        = 4;
    localparam int ADDR_TEMP       = 5;
    localparam int ADDR_CTE_NEGONE = 6;
    localparam int ADDR_ACC        = 7;

    // Entry 0 sits in the least significant byte.
    localparam logic [63:0] DEFAULT_INIT_VEC = 64'hF0FF_0004_0300_FF00;

endpackage

// File: rtl/register_bank_mp_sp_unit.sv
// Stack-pointer next-state logic with push/pop boundary detection.
// A general write to SP overrides the op and suppresses both events.
module register_bank_mp_sp_unit
    import register_bank_mp_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] sp_q,
    input  logic [1:0]            sp_op,
    input  logic                  wr_override,
    output logic [DATA_WIDTH-1:0] sp_d,
    output logic                  ovf_evt,
    output logic                  unf_evt
);

    sp_op_e op;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        sp_d    = sp_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        op      = sp_op_e'(sp_op);
        if (!wr_override) begin
            case (op)
                SP_PUSH: begin
                    if (sp_q == '0) ovf_evt = 1'b1;
                    else            sp_d    = sp_q - 1'b1;
                end
                SP_POP: begin
                    if (sp_q == '1) unf_evt = 1'b1;
                    else            sp_d    = sp_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/register_bank_mp.sv
// Parametrised register bank: two dynamic read ports plus a fixed accumulator
// bus, PC auto-increment, SP push/pop, constant-register write protection.
module register_bank_mp
    import register_bank_mp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int PC_ADDR    = ADDR_PC,
    parameter int SP_ADDR    = ADDR_SP,
    parameter int CONST_ADDR = ADDR_CTE_NEGONE,
    parameter int ACC_ADDR   = ADDR_ACC,
    parameter int BYPASS     = 1,
    parameter logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0] INIT_VEC = DEFAULT_INIT_VEC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr_a,
    input  logic [ADDR_WIDTH-1:0] r_addr_b,
    input  logic                  pc_inc,
    input  logic [1:0]            sp_op,
    input  logic                  flag_clr,
    output logic [DATA_WIDTH-1:0] bus_acc,
    output logic [DATA_WIDTH-1:0] bus_a,
    output logic [DATA_WIDTH-1:0] bus_b,
    output logic                  sp_ovf,
    output logic                  sp_unf,
    output logic                  wr_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] PC_A    = PC_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] SP_A    = SP_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] CONST_A = CONST_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] ACC_A   = ACC_ADDR[ADDR_WIDTH-1:0];

    generate
        if (PC_ADDR >= DEPTH || SP_ADDR >= DEPTH || CONST_ADDR >= DEPTH || ACC_ADDR >= DEPTH ||
            PC_ADDR == SP_ADDR || PC_ADDR == CONST_ADDR || PC_ADDR == ACC_ADDR ||
            SP_ADDR == CONST_ADDR || SP_ADDR == ACC_ADDR || CONST_ADDR == ACC_ADDR) begin : g_bad_addr
            $error("register_bank_mp: special addresses must be distinct and below the depth");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic                  sp_ovf_q, sp_ovf_d;
    logic                  sp_unf_q, sp_unf_d;
    logic                  wr_err_q, wr_err_d;

    logic                  wr_ok;
    logic                  wr_const;
    logic                  wr_pc;
    logic                  wr_sp;
    logic [DATA_WIDTH-1:0] sp_next;
    logic                  ovf_evt;
    logic                  unf_evt;

    assign wr_const = w_en && (w_addr == CONST_A);
    assign wr_ok    = w_en && (w_addr != CONST_A);
    assign wr_pc    = w_en && (w_addr == PC_A);
    assign wr_sp    = w_en && (w_addr == SP_A);

    register_bank_mp_sp_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sp_unit (
        .sp_q        (regs_q[SP_A]),
        .sp_op       (sp_op),
        .wr_override (wr_sp),
        .sp_d        (sp_next),
        .ovf_evt     (ovf_evt),
        .unf_evt     (unf_evt)
    );

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) regs_d[w_addr] = w_data;
        if (pc_inc && !wr_pc) regs_d[PC_A] = regs_q[PC_A] + 1'b1;
        if (!wr_sp) regs_d[SP_A] = sp_next;

        // A new event wins over a simultaneous clear.
        sp_ovf_d = (sp_ovf_q && !flag_clr) || ovf_evt;
        sp_unf_d = (sp_unf_q && !flag_clr) || unf_evt;
        wr_err_d = (wr_err_q && !flag_clr) || wr_const;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file is reset on purpose; INIT_VEC is its architectural power-on image.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= INIT_VEC[i*DATA_WIDTH +: DATA_WIDTH];
            end
            sp_ovf_q <= 1'b0;
            sp_unf_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            sp_ovf_q <= sp_ovf_d;
            sp_unf_q <= sp_unf_d;
            wr_err_q <= wr_err_d;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [DATA_WIDTH-1:0] stored);
        if ((BYPASS != 0) && wr_ok && (w_addr == addr)) return w_data;
        return stored;
    endfunction

    assign bus_acc = read_port(ACC_A, regs_q[ACC_A]);
    assign bus_a   = read_port(r_addr_a, regs_q[r_addr_a]);
    assign bus_b   = read_port(r_addr_b, regs_q[r_addr_b]);

    assign sp_ovf = sp_ovf_q;
    assign sp_unf = sp_unf_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_register_bank_mp.sv
// Directed self-checking bench for register_bank_mp with default parameters.
module tb_register_bank_mp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_en = 1'b0;
    logic [2:0] w_addr = '0;
    logic [7:0] w_data = '0;
    logic [2:0] r_addr_a = '0;
    logic [2:0] r_addr_b = '0;
    logic       pc_inc = 1'b0;
    logic [1:0] sp_op = 2'b00;
    logic       flag_clr = 1'b0;
    logic [7:0] bus_acc, bus_a, bus_b;
    logic       sp_ovf, sp_unf, wr_err;

    int errors = 0;
    int checks = 0;

    register_bank_mp dut (
        .clk      (clk),
        .rst      (rst),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .r_addr_a (r_addr_a),
        .r_addr_b (r_addr_b),
        .pc_inc   (pc_inc),
        .sp_op    (sp_op),
        .flag_clr (flag_clr),
        .bus_acc  (bus_acc),
        .bus_a    (bus_a),
        .bus_b    (bus_b),
        .sp_ovf   (sp_ovf),
        .sp_unf   (sp_unf),
        .wr_err   (wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then a mid-cycle reset must override a pending write.
        #12 rst = 1'b0;
        tick();
        w_en = 1'b1; w_addr = 3'd4; w_data = 8'h99;
        tick();
        w_en = 1'b0; r_addr_a = 3'd4;
        #1 check("pre_rst_write", bus_a, 8'h99);
        w_en = 1'b1; w_addr = 3'd3; w_data = 8'hAA;
        #2 rst = 1'b1;
        tick();
        #2 rst = 1'b0;
        w_en = 1'b0; r_addr_a = 3'd3; r_addr_b = 3'd1;
        #1;
        check("rst_reg3", bus_a, 8'h03);
        check("rst_sp", bus_b, 8'hFF);
        check("rst_acc", bus_acc, 8'hF0);
        check("rst_flags", {5'b0, sp_ovf, sp_unf, wr_err}, 8'h00);
        r_addr_a = 3'd4;
        #1 check("rst_reg4", bus_a, 8'h04);

        // Bypass onto ACC and port A; constant register protected.
        w_en = 1'b1; w_addr = 3'd7; w_data = 8'h5A; r_addr_a = 3'd7;
        #1;
        check("byp_acc", bus_acc, 8'h5A);
        check("byp_a", bus_a, 8'h5A);
        tick();
        w_en = 1'b0;
        #1 check("acc_stored", bus_acc, 8'h5A);
        w_en = 1'b1; w_addr = 3'd6; w_data = 8'h00; r_addr_b = 3'd6;
        #1 check("const_no_bypass", bus_b, 8'hFF);
        tick();
        w_en = 1'b0;
        #1;
        check("const_kept", bus_b, 8'hFF);
        check("wr_err_set", {7'b0, wr_err}, 8'h01);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        #1 check("wr_err_clr", {7'b0, wr_err}, 8'h00);

        // PC wrap and write-over-increment priority.
        w_en = 1'b1; w_addr = 3'd0; w_data = 8'hFE;
        tick();
        w_en = 1'b0; pc_inc = 1'b1; r_addr_a = 3'd0;
        #1 check("pc_fe", bus_a, 8'hFE);
        tick();
        check("pc_ff", bus_a, 8'hFF);
        tick();
        pc_inc = 1'b0;
        #1 check("pc_wrap", bus_a, 8'h00);
        pc_inc = 1'b1; w_en = 1'b1; w_addr = 3'd0; w_data = 8'h40;
        tick();
        pc_inc = 1'b0; w_en = 1'b0;
        #1 check("pc_wr_prio", bus_a, 8'h40);

        // SP pop underflow, push to zero, push overflow, clear.
        sp_op = 2'b10; r_addr_b = 3'd1;
        tick();
        sp_op = 2'b00;
        #1;
        check("pop_unf_sp", bus_b, 8'hFF);
        check("pop_unf_flag", {6'b0, sp_ovf, sp_unf}, 8'h01);
        w_en = 1'b1; w_addr = 3'd1; w_data = 8'h01;
        tick();
        w_en = 1'b0; sp_op = 2'b01;
        tick();
        check("push_to_0", bus_b, 8'h00);
        check("push_no_ovf", {7'b0, sp_ovf}, 8'h00);
        tick();
        sp_op = 2'b00;
        #1;
        check("push_ovf_sp", bus_b, 8'h00);
        check("push_ovf_flag", {7'b0, sp_ovf}, 8'h01);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        #1 check("flags_clr", {6'b0, sp_ovf, sp_unf}, 8'h00);

        // Set wins over a simultaneous clear.
        flag_clr = 1'b1; sp_op = 2'b01;
        tick();
        flag_clr = 1'b0; sp_op = 2'b00;
        #1 check("set_over_clr", {7'b0, sp_ovf}, 8'h01);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;

        // SP write drops a boundary push without flagging.
        w_en = 1'b1; w_addr = 3'd1; w_data = 8'h05; sp_op = 2'b01;
        tick();
        w_en = 1'b0; sp_op = 2'b00;
        #1;
        check("sp_wr_prio", bus_b, 8'h05);
        check("sp_wr_no_ovf", {7'b0, sp_ovf}, 8'h00);

        // PC increment, push and a TEMP write in one cycle.
        pc_inc = 1'b1; sp_op = 2'b01; w_en = 1'b1; w_addr = 3'd5; w_data = 8'h77;
        tick();
        pc_inc = 1'b0; sp_op = 2'b00; w_en = 1'b0; r_addr_a = 3'd0; r_addr_b = 3'd1;
        #1;
        check("conc_pc", bus_a, 8'h41);
        check("conc_sp", bus_b, 8'h04);
        r_addr_a = 3'd5;
        #1 check("conc_temp", bus_a, 8'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
